// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline constants. Opcodes, instruction field bit
//               positions and register-address width derivation, used by
//               the register file, decode and execute stages.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // Instruction field positions (low bit of each field)
    localparam int OPC_LO  = 0;
    localparam int RD_LO   = 7;
    localparam int RS1_LO  = 15;
    localparam int RS2_LO  = 20;
    localparam int IMM_LO  = 20;
    localparam int IMM_W   = 12;

    // Ceiling log2 of n, evaluated at elaboration time
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(n)) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // Register-address width for a register file of n entries; never below 1
    function automatic int addr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/operand_bypass.sv
`default_nettype none
// ============================================================================
// Module      : operand_bypass
// Description : Selects one source operand: register 0 reads as zero, a
//               matching writeback write overrides the supplied data,
//               otherwise the supplied data passes through.
// Revision    : 1.0 - initial release
// ============================================================================
module operand_bypass #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_rf_data,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [WIDTH-1:0]  i_wb_data,
    output logic [WIDTH-1:0]  o_data
);

    // Zero register first, then writeback override, else the supplied value
    always_comb begin
        o_data = i_rf_data;
        if (i_addr == '0) begin
            o_data = '0;
        end else if (i_wb_en && (i_wb_addr == i_addr)) begin
            o_data = i_wb_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_stage
// Description : Decode/operand stage. Drives register-file read addresses,
//               merges same-cycle writeback data, detects load-use hazards
//               and holds the result in a registered ID/EX slot with a
//               valid/ready handshake toward execute.
// Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = addr_width(NREGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_valid,
    output logic              if_ready,
    input  logic [WIDTH-1:0]  if_instr,
    input  logic [WIDTH-1:0]  if_pc,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    input  logic [WIDTH-1:0]  rf_rd_data_1,
    input  logic [WIDTH-1:0]  rf_rd_data_2,
    input  logic              wb_wr_en,
    input  logic [ADDR_W-1:0] wb_wr_addr,
    input  logic [WIDTH-1:0]  wb_wr_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [WIDTH-1:0]  ex_pc,
    output logic [WIDTH-1:0]  ex_instr,
    output logic [WIDTH-1:0]  ex_op_a,
    output logic [WIDTH-1:0]  ex_op_b,
    output logic [WIDTH-1:0]  ex_imm,
    output logic [ADDR_W-1:0] ex_rs1,
    output logic [ADDR_W-1:0] ex_rs2,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_is_load
);

    logic              r_ex_valid;
    logic [WIDTH-1:0]  r_ex_pc;
    logic [WIDTH-1:0]  r_ex_instr;
    logic [WIDTH-1:0]  r_ex_op_a;
    logic [WIDTH-1:0]  r_ex_op_b;
    logic [WIDTH-1:0]  r_ex_imm;
    logic [ADDR_W-1:0] r_ex_rs1;
    logic [ADDR_W-1:0] r_ex_rs2;
    logic [ADDR_W-1:0] r_ex_rd;
    logic              r_ex_is_load;

    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic [ADDR_W-1:0] w_rd;
    logic [WIDTH-1:0]  w_imm;
    logic              w_is_load;
    logic              w_hold;
    logic              w_hazard;
    logic              w_accept;
    logic [ADDR_W-1:0] w_bp_addr_a;
    logic [ADDR_W-1:0] w_bp_addr_b;
    logic [WIDTH-1:0]  w_bp_data_a;
    logic [WIDTH-1:0]  w_bp_data_b;
    logic [WIDTH-1:0]  w_op_a;
    logic [WIDTH-1:0]  w_op_b;

    // Field decode of the offered instruction
    assign w_rs1     = if_instr[RS1_LO +: ADDR_W];
    assign w_rs2     = if_instr[RS2_LO +: ADDR_W];
    assign w_rd      = if_instr[RD_LO  +: ADDR_W];
    assign w_imm     = {{(WIDTH-IMM_W){if_instr[IMM_LO+IMM_W-1]}}, if_instr[IMM_LO +: IMM_W]};
    assign w_is_load = (if_instr[OPC_LO +: 7] == OPC_LOAD);

    assign rf_rs1 = w_rs1;
    assign rf_rs2 = w_rs2;

    // Slot is stalled by execute; any accept is impossible in this state
    assign w_hold = r_ex_valid & ~ex_ready;

    // Both sources compared regardless of whether the opcode uses them
    assign w_hazard = r_ex_valid & r_ex_is_load & (r_ex_rd != '0) &
                      ((r_ex_rd == w_rs1) | (r_ex_rd == w_rs2));

    assign if_ready = ~flush & ~w_hazard & (~r_ex_valid | ex_ready);
    assign w_accept = if_valid & if_ready;

    // The bypass muxes serve the incoming operands normally, and are turned
    // around to snoop the held slot's operands while execute is stalled.
    assign w_bp_addr_a = w_hold ? r_ex_rs1  : w_rs1;
    assign w_bp_addr_b = w_hold ? r_ex_rs2  : w_rs2;
    assign w_bp_data_a = w_hold ? r_ex_op_a : rf_rd_data_1;
    assign w_bp_data_b = w_hold ? r_ex_op_b : rf_rd_data_2;

    operand_bypass #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bypass_a (
        .i_addr    (w_bp_addr_a),
        .i_rf_data (w_bp_data_a),
        .i_wb_en   (wb_wr_en),
        .i_wb_addr (wb_wr_addr),
        .i_wb_data (wb_wr_data),
        .o_data    (w_op_a)
    );

    operand_bypass #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bypass_b (
        .i_addr    (w_bp_addr_b),
        .i_rf_data (w_bp_data_b),
        .i_wb_en   (wb_wr_en),
        .i_wb_addr (wb_wr_addr),
        .i_wb_data (wb_wr_data),
        .o_data    (w_op_b)
    );

    // ID/EX slot: reset, then flush, then capture, hold-with-snoop, or drain
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_pc      <= '0;
            r_ex_instr   <= '0;
            r_ex_op_a    <= '0;
            r_ex_op_b    <= '0;
            r_ex_imm     <= '0;
            r_ex_rs1     <= '0;
            r_ex_rs2     <= '0;
            r_ex_rd      <= '0;
            r_ex_is_load <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_pc      <= if_pc;
            r_ex_instr   <= if_instr;
            r_ex_op_a    <= w_op_a;
            r_ex_op_b    <= w_op_b;
            r_ex_imm     <= w_imm;
            r_ex_rs1     <= w_rs1;
            r_ex_rs2     <= w_rs2;
            r_ex_rd      <= w_rd;
            r_ex_is_load <= w_is_load;
        end else if (w_hold) begin
            r_ex_op_a <= w_op_a;
            r_ex_op_b <= w_op_b;
        end else begin
            r_ex_valid <= 1'b0;
        end
    end

    assign ex_valid   = r_ex_valid;
    assign ex_pc      = r_ex_pc;
    assign ex_instr   = r_ex_instr;
    assign ex_op_a    = r_ex_op_a;
    assign ex_op_b    = r_ex_op_b;
    assign ex_imm     = r_ex_imm;
    assign ex_rs1     = r_ex_rs1;
    assign ex_rs2     = r_ex_rs2;
    assign ex_rd      = r_ex_rd;
    assign ex_is_load = r_ex_is_load;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_stage
// Description : Self-checking bench for id_stage. Directed scenarios plus
//               randomized traffic against a behavioural slot/regfile model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clock;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_rs1;
    logic [4:0]  rf_rs2;
    logic [31:0] rf_rd_data_1;
    logic [31:0] rf_rd_data_2;
    logic        wb_wr_en;
    logic [4:0]  wb_wr_addr;
    logic [31:0] wb_wr_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_instr;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;

    id_stage #(.WIDTH(32), .NREGS(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_rd_data_1 (rf_rd_data_1),
        .rf_rd_data_2 (rf_rd_data_2),
        .wb_wr_en     (wb_wr_en),
        .wb_wr_addr   (wb_wr_addr),
        .wb_wr_data   (wb_wr_data),
        .flush        (flush),
        .ex_ready     (ex_ready),
        .ex_valid     (ex_valid),
        .ex_pc        (ex_pc),
        .ex_instr     (ex_instr),
        .ex_op_a      (ex_op_a),
        .ex_op_b      (ex_op_b),
        .ex_imm       (ex_imm),
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Architectural register contents as the register file would return them
    logic [31:0] regs [32];

    // Expected contents of the ID/EX slot
    logic        m_valid;
    logic [31:0] m_pc, m_instr, m_a, m_b, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        m_ld;
    logic        obs_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [6:0] hi7);
        return {hi7, rs2, rs1, 3'b000, rd, opc};
    endfunction

    // Source operand per the architectural rules
    function automatic logic [31:0] opnd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (wb_wr_en && wb_wr_addr == a) return wb_wr_data;
        return regs[a];
    endfunction

    // One clock: check combinational outputs, advance the model, check slot
    task automatic cycle();
        logic [4:0] s1, s2;
        logic       hz, rdy, was_rst;
        s1 = if_instr[19:15];
        s2 = if_instr[24:20];
        rf_rd_data_1 = regs[s1];
        rf_rd_data_2 = regs[s2];
        #1;
        hz  = m_valid && m_ld && (m_rd != 0) && (m_rd == s1 || m_rd == s2);
        rdy = !flush && !hz && (!m_valid || ex_ready);
        obs_rdy = if_ready;
        chk("if_ready", {31'd0, if_ready}, {31'd0, rdy});
        chk("rf_rs1", {27'd0, rf_rs1}, {27'd0, s1});
        chk("rf_rs2", {27'd0, rf_rs2}, {27'd0, s2});
        was_rst = reset;
        if (reset) begin
            m_valid = 0; m_pc = 0; m_instr = 0; m_a = 0; m_b = 0; m_imm = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ld = 0;
        end else if (flush) begin
            m_valid = 0;
        end else if (if_valid && rdy) begin
            m_valid = 1;
            m_pc    = if_pc;
            m_instr = if_instr;
            m_a     = opnd(s1);
            m_b     = opnd(s2);
            m_imm   = 32'($signed(if_instr[31:20]));
            m_rs1   = s1;
            m_rs2   = s2;
            m_rd    = if_instr[11:7];
            m_ld    = (if_instr[6:0] == 7'b0000011);
        end else if (m_valid && !ex_ready) begin
            if (wb_wr_en && wb_wr_addr == m_rs1 && m_rs1 != 0) m_a = wb_wr_data;
            if (wb_wr_en && wb_wr_addr == m_rs2 && m_rs2 != 0) m_b = wb_wr_data;
        end else begin
            m_valid = 0;
        end
        @(posedge clock);
        #1;
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        if (m_valid || was_rst) begin
            chk("ex_pc", ex_pc, m_pc);
            chk("ex_instr", ex_instr, m_instr);
            chk("ex_op_a", ex_op_a, m_a);
            chk("ex_op_b", ex_op_b, m_b);
            chk("ex_imm", ex_imm, m_imm);
            chk("ex_rs1", {27'd0, ex_rs1}, {27'd0, m_rs1});
            chk("ex_rs2", {27'd0, ex_rs2}, {27'd0, m_rs2});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, m_ld});
        end
        if (wb_wr_en && wb_wr_addr != 0) regs[wb_wr_addr] = wb_wr_data;
        @(negedge clock);
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                         input logic er, input logic fl, input logic rs,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if_valid = iv; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
        reset = rs; wb_wr_en = we; wb_wr_addr = wa; wb_wr_data = wd;
        cycle();
    endtask

    initial begin
        logic [6:0] opcs [3];
        opcs[0] = 7'b0000011; opcs[1] = 7'b0010011; opcs[2] = 7'b0110011;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
        regs[0] = 32'hBAD0_BAD0;
        m_valid = 0; m_pc = 0; m_instr = 0; m_a = 0; m_b = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ld = 0; obs_rdy = 0;
        if_valid = 0; if_instr = 0; if_pc = 0; ex_ready = 1; flush = 0; reset = 1;
        wb_wr_en = 0; wb_wr_addr = 0; wb_wr_data = 0; rf_rd_data_1 = 0; rf_rd_data_2 = 0;
        @(negedge clock);

        // Reset state
        drive(0, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_ex_op_a", ex_op_a, 32'd0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
        chk("rst_if_ready", {31'd0, obs_rdy}, 32'd1);

        // addi x5,x1,7 with x1 = 10
        regs[1] = 32'd10;
        drive(1, mk(7'b0010011, 5'd5, 5'd1, 5'd7, 7'd0), 32'h100, 1, 0, 0, 0, 0, 0);
        chk("addi_op_a", ex_op_a, 32'd10);
        chk("addi_imm", ex_imm, 32'd7);
        chk("addi_rd", {27'd0, ex_rd}, 32'd5);

        // Same-cycle writeback bypass
        regs[3] = 32'd0;
        drive(1, mk(7'b0010011, 5'd9, 5'd3, 5'd0, 7'd0), 32'h104, 1, 0, 0, 1, 5'd3, 32'hDEAD);
        chk("bypass_op_a", ex_op_a, 32'hDEAD);

        // x0 source never bypassed, even with a write to x0
        drive(1, mk(7'b0010011, 5'd9, 5'd0, 5'd0, 7'h7F), 32'h108, 1, 0, 0, 1, 5'd0, 32'h55);
        chk("x0_op_a", ex_op_a, 32'd0);
        chk("neg_imm", ex_imm, 32'hFFFF_FFE0);

        // Load-use: lw x4 then add x6,x4,x2
        drive(1, mk(7'b0000011, 5'd4, 5'd1, 5'd0, 7'd0), 32'h10C, 1, 0, 0, 0, 0, 0);
        drive(1, mk(7'b0110011, 5'd6, 5'd4, 5'd2, 7'd0), 32'h110, 1, 0, 0, 0, 0, 0);
        chk("lu_stall_rdy", {31'd0, obs_rdy}, 32'd0);
        chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
        drive(1, mk(7'b0110011, 5'd6, 5'd4, 5'd2, 7'd0), 32'h110, 1, 0, 0, 0, 0, 0);
        chk("lu_accept_rdy", {31'd0, obs_rdy}, 32'd1);
        chk("lu_accept_rd", {27'd0, ex_rd}, 32'd6);
        // lw x0 creates no stall
        drive(1, mk(7'b0000011, 5'd0, 5'd1, 5'd0, 7'd0), 32'h114, 1, 0, 0, 0, 0, 0);
        drive(1, mk(7'b0110011, 5'd6, 5'd0, 5'd0, 7'd0), 32'h118, 1, 0, 0, 0, 0, 0);
        chk("lw_x0_rdy", {31'd0, obs_rdy}, 32'd1);

        // Hold snoop on ex_rs2 = 7
        drive(1, mk(7'b0110011, 5'd8, 5'd1, 5'd7, 7'd0), 32'h11C, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h1234);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("snoop_op_b", ex_op_b, 32'h1234);
        chk("snoop_op_a", ex_op_a, 32'd10);
        chk("snoop_pc", ex_pc, 32'h11C);
        drive(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Flush with a full slot and an offered instruction
        drive(1, mk(7'b0010011, 5'd10, 5'd2, 5'd0, 7'd0), 32'h120, 1, 0, 0, 0, 0, 0);
        drive(1, mk(7'b0010011, 5'd11, 5'd2, 5'd0, 7'd0), 32'h124, 1, 1, 0, 0, 0, 0);
        chk("flush_rdy", {31'd0, obs_rdy}, 32'd0);
        chk("flush_valid", {31'd0, ex_valid}, 32'd0);

        // Reset (with flush) during a stall drops the held instruction
        drive(1, mk(7'b0010011, 5'd12, 5'd2, 5'd0, 7'd0), 32'h128, 1, 0, 0, 0, 0, 0);
        drive(1, mk(7'b0010011, 5'd13, 5'd2, 5'd0, 7'd0), 32'h12C, 0, 0, 0, 0, 0, 0);
        drive(1, mk(7'b0010011, 5'd13, 5'd2, 5'd0, 7'd0), 32'h12C, 0, 1, 1, 0, 0, 0);
        chk("rst_stall_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_stall_op_a", ex_op_a, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            ins = mk(opcs[$urandom_range(0, 2)], 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 7'($urandom));
            drive(($urandom_range(0, 3) != 0), ins, $urandom,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
